// File: rtl/i2s_adc_receiver.sv
// I2S ADC capture: oversamples the codec bit clock, LR clock and data on clk and
// deserialises them into left/right sample pairs behind a valid/ready port.
module i2s_adc_receiver #(
    parameter int SAMPLE_BITS = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_in,
    input  logic                   enable,
    input  logic                   aud_bclk,
    input  logic                   aud_adclrck,
    input  logic                   aud_adcdat,
    output logic [SAMPLE_BITS-1:0] left,
    output logic [SAMPLE_BITS-1:0] right,
    output logic                   valid,
    input  logic                   ready,
    output logic                   overrun,
    output logic                   frame_err,
    input  logic                   err_clear
);

    localparam int CNT_W = $clog2(SAMPLE_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_BITS - 1);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LEFT,
        ST_RIGHT
    } state_t;

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   bclk_prev;
    logic                   bclk_s;
    logic                   lrck_s;
    logic                   dat_s;
    logic                   rise_p0;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [SAMPLE_BITS-1:0] shift_p1;
    logic [SAMPLE_BITS-1:0] shift_nxt;
    logic [SAMPLE_BITS-1:0] left_hold;
    logic                   lrck_prev;
    logic                   hold_load;
    logic                   pair_done;
    logic                   ferr_set;
    logic                   vld_p1;
    logic                   ovr_set;

    // Stage p0: input synchronisers and bit-clock rise detection
    always_ff @(posedge clk) begin
        if (reset_in) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], aud_bclk};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], aud_adclrck};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], aud_adcdat};
            bclk_prev <= bclk_s;
        end
    end

    assign bclk_s  = bclk_sync[SYNC_STAGES-1];
    assign lrck_s  = lrck_sync[SYNC_STAGES-1];
    assign dat_s   = dat_sync[SYNC_STAGES-1];
    assign rise_p0 = bclk_s & ~bclk_prev;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_nxt = shift_p1;
        hold_load = 1'b0;
        pair_done = 1'b0;
        ferr_set  = 1'b0;
        if (!enable) begin
            state_nxt = ST_HUNT;
            cnt_nxt   = '0;
        end else if (rise_p0) begin
            if (lrck_s != lrck_prev) begin
                // The transition rise carries the previous slot's LSB, never captured
                cnt_nxt = '0;
                case (state)
                    ST_HUNT: begin
                        if (!lrck_s) state_nxt = ST_LEFT;
                    end
                    ST_LEFT: begin
                        if (cnt != CNT_FULL) begin
                            ferr_set  = 1'b1;
                            state_nxt = lrck_s ? ST_HUNT : ST_LEFT;
                        end else if (lrck_s) begin
                            hold_load = 1'b1;
                            state_nxt = ST_RIGHT;
                        end else begin
                            state_nxt = ST_LEFT;
                        end
                    end
                    ST_RIGHT: begin
                        // A short slot drops to hunt, and this same 1->0 rise restarts left
                        if (cnt != CNT_FULL) ferr_set = 1'b1;
                        state_nxt = lrck_s ? ST_HUNT : ST_LEFT;
                    end
                    default: state_nxt = ST_HUNT;
                endcase
            end else if (state != ST_HUNT && cnt != CNT_FULL) begin
                shift_nxt = {shift_p1[SAMPLE_BITS-2:0], dat_s};
                cnt_nxt   = cnt + 1'b1;
                if (state == ST_RIGHT && cnt == CNT_LAST) pair_done = 1'b1;
            end
        end
    end

    // Stage p1: slot FSM, shift register and left holding register
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state     <= ST_HUNT;
            cnt       <= '0;
            lrck_prev <= 1'b0;
            vld_p1    <= 1'b0;
            left_hold <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            vld_p1 <= pair_done;
            if (rise_p0) lrck_prev <= lrck_s;
            if (!enable) left_hold <= '0;
            else if (hold_load) left_hold <= shift_p1;
        end
    end

    always_ff @(posedge clk) begin
        shift_p1 <= shift_nxt;
    end

    assign ovr_set = enable & vld_p1 & valid & ~ready;

    // Stage p2: output pair register and handshake
    always_ff @(posedge clk) begin
        if (reset_in) begin
            left  <= '0;
            right <= '0;
            valid <= 1'b0;
        end else if (!enable) begin
            valid <= 1'b0;
        end else if (vld_p1 && (!valid || ready)) begin
            left  <= left_hold;
            right <= shift_p1;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= (overrun & ~err_clear) | ovr_set;
            frame_err <= (frame_err & ~err_clear) | ferr_set;
        end
    end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver: drives I2S frames on the codec pins
// (clk:bclk = 40:1, 32-bit slots) and checks pairs, handshake and sticky flags.
`timescale 1ns/1ps
module tb_i2s_adc_receiver;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        enable;
    logic        aud_bclk;
    logic        aud_adclrck;
    logic        aud_adcdat;
    logic [15:0] left;
    logic [15:0] right;
    logic        valid;
    logic        ready;
    logic        overrun;
    logic        frame_err;
    logic        err_clear;

    int          checks = 0;
    int          failures = 0;
    int          n_acc = 0;
    logic [15:0] acc_l = '0;
    logic [15:0] acc_r = '0;
    logic        track_drop = 1'b0;
    logic        dropped = 1'b0;
    int          n_before;

    i2s_adc_receiver #(.SAMPLE_BITS(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_in   (reset_in),
        .enable     (enable),
        .aud_bclk   (aud_bclk),
        .aud_adclrck(aud_adclrck),
        .aud_adcdat (aud_adcdat),
        .left       (left),
        .right      (right),
        .valid      (valid),
        .ready      (ready),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .err_clear  (err_clear)
    );

    always #4 clk = ~clk;

    // Records every accepted pair and any valid drop while tracking is armed
    always @(negedge clk) begin
        if (valid && ready) begin
            n_acc <= n_acc + 1;
            acc_l <= left;
            acc_r <= right;
        end
        if (track_drop && !valid) dropped <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One slot of nrises bclk rises; rise 0 carries the previous slot's LSB,
    // rises 1..16 carry w MSB first. At rise 'hit', ready is pulsed on the
    // clk edge where the completed pair would be loaded.
    task automatic send_slot(input logic lr, input logic [15:0] w, input int nrises, input int hit);
        longint t0;
        for (int k = 0; k < nrises; k++) begin
            aud_bclk    = 1'b0;
            aud_adclrck = lr;
            aud_adcdat  = (k >= 1 && k <= 16) ? w[16-k] : 1'b0;
            #160;
            aud_bclk = 1'b1;
            if (k == hit) begin
                t0 = $time;
                repeat (3) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                #1 ready = 1'b0;
                #(160 - ($time - t0));
            end else begin
                #160;
            end
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l, 32, -1);
        send_slot(1'b1, r, 32, -1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_in    = 1'b1;
        enable      = 1'b1;
        ready       = 1'b1;
        err_clear   = 1'b0;
        aud_bclk    = 1'b0;
        aud_adclrck = 1'b0;
        aud_adcdat  = 1'b0;
        tick(3);
        chk("rst_left", 32'(left), 32'h0);
        chk("rst_right", 32'(right), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        reset_in = 1'b0;
        tick(2);

        // Basic capture with ready held high
        send_slot(1'b1, 16'h0000, 32, -1);
        send_frame(16'h8001, 16'h7FFE);
        chk("t1_count1", 32'(n_acc), 32'd1);
        send_frame(16'h8001, 16'h7FFE);
        chk("t1_count2", 32'(n_acc), 32'd2);
        chk("t1_left", 32'(acc_l), 32'h8001);
        chk("t1_right", 32'(acc_r), 32'h7FFE);
        chk("t1_valid_idle", 32'(valid), 32'h0);

        // Backpressure: first pair held, later ones dropped with overrun
        ready = 1'b0;
        send_frame(16'h0001, 16'h0002);
        chk("t2_ovr_single", 32'(overrun), 32'h0);
        send_frame(16'h0003, 16'h0004);
        send_frame(16'h0005, 16'h0006);
        chk("t2_valid", 32'(valid), 32'h1);
        chk("t2_left", 32'(left), 32'h0001);
        chk("t2_right", 32'(right), 32'h0002);
        chk("t2_overrun", 32'(overrun), 32'h1);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        chk("t2_ovr_clear", 32'(overrun), 32'h0);
        chk("t2_valid_kept", 32'(valid), 32'h1);
        ready = 1'b1;
        tick(1);
        chk("t2_acc_count", 32'(n_acc), 32'd3);
        chk("t2_acc_pair", {acc_l, acc_r}, 32'h0001_0002);
        chk("t2_valid_drop", 32'(valid), 32'h0);

        // Accept in the same cycle a new pair completes
        ready = 1'b0;
        send_frame(16'h0011, 16'h0022);
        chk("t3_pend_pair", {left, right}, 32'h0011_0022);
        dropped    = 1'b0;
        track_drop = 1'b1;
        send_slot(1'b0, 16'h0033, 32, -1);
        send_slot(1'b1, 16'h0044, 32, 16);
        track_drop = 1'b0;
        chk("t3_no_drop", 32'(dropped), 32'h0);
        chk("t3_valid", 32'(valid), 32'h1);
        chk("t3_new_pair", {left, right}, 32'h0033_0044);
        chk("t3_old_acc", {acc_l, acc_r}, 32'h0011_0022);
        chk("t3_overrun", 32'(overrun), 32'h0);
        ready = 1'b1;
        tick(2);
        chk("t3_final_acc", {acc_l, acc_r}, 32'h0033_0044);

        // Short right slot
        n_before = n_acc;
        send_slot(1'b0, 16'hAAAA, 32, -1);
        send_slot(1'b1, 16'hBBBB, 10, -1);
        chk("t4_no_pair", 32'(n_acc - n_before), 32'd0);
        send_frame(16'h1234, 16'h5678);
        chk("t4_frame_err", 32'(frame_err), 32'h1);
        chk("t4_one_pair", 32'(n_acc - n_before), 32'd1);
        chk("t4_pair", {acc_l, acc_r}, 32'h1234_5678);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        chk("t4_ferr_clear", 32'(frame_err), 32'h0);

        // Reset pulse in the middle of a left slot
        n_before = n_acc;
        send_slot(1'b0, 16'h1111, 8, -1);
        reset_in = 1'b1;
        tick(1);
        reset_in = 1'b0;
        send_slot(1'b0, 16'h0000, 24, -1);
        send_slot(1'b1, 16'h2222, 32, -1);
        chk("t5_no_pair", 32'(n_acc - n_before), 32'd0);
        chk("t5_valid", 32'(valid), 32'h0);
        send_frame(16'h0F0F, 16'hF0F0);
        chk("t5_one_pair", 32'(n_acc - n_before), 32'd1);
        chk("t5_pair", {acc_l, acc_r}, 32'h0F0F_F0F0);
        chk("t5_frame_err", 32'(frame_err), 32'h0);

        // Enable drop with a pair pending
        ready = 1'b0;
        send_frame(16'h0A0A, 16'h0B0B);
        chk("t6_pending", 32'(valid), 32'h1);
        enable = 1'b0;
        tick(1);
        chk("t6_valid_off", 32'(valid), 32'h0);
        send_slot(1'b0, 16'h0C0C, 32, -1);
        enable = 1'b1;
        send_slot(1'b1, 16'h0D0D, 32, -1);
        chk("t6_orphan_right", 32'(valid), 32'h0);
        n_before = n_acc;
        ready    = 1'b1;
        send_frame(16'h4321, 16'h8765);
        chk("t6_one_pair", 32'(n_acc - n_before), 32'd1);
        chk("t6_pair", {acc_l, acc_r}, 32'h4321_8765);
        chk("t6_overrun", 32'(overrun), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
